// File: rtl/usb_control_cpu_mul_pkg.sv
// Shared types for the usb_control CPU multiply/shift pipe.
// Op encoding, default widths and the first-stage control record.
package usb_control_cpu_mul_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_SH_W   = 5;

  typedef enum logic [1:0] {
    OP_MUL = 2'd0,
    OP_SHL = 2'd1,
    OP_SHR = 2'd2,
    OP_ROL = 2'd3
  } mul_op_e;

  // hi = take the upper half of the product (MUL hi, or SHR with a non-zero amount)
  typedef struct packed {
    logic    valid;
    mul_op_e op;
    logic    hi;
  } stage_ctl_t;

endpackage

// File: rtl/usb_control_cpu_mul_shift_pipe_if.sv
// Operand/result handshake bundle between execute (producer) and writeback (consumer).
// Both sides: a beat transfers on a rising edge where valid && ready; valid holds and payload stays stable until then.
interface usb_control_cpu_mul_shift_pipe_if
  import usb_control_cpu_mul_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);
  logic              in_valid;
  logic              in_ready;
  mul_op_e           in_op;
  logic              in_hi;
  logic              in_src1_sgn;
  logic              in_src2_sgn;
  logic [DATA_W-1:0] in_src1;
  logic [DATA_W-1:0] in_src2;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;

  modport master (
    output in_valid, in_op, in_hi, in_src1_sgn, in_src2_sgn, in_src1, in_src2, out_ready,
    input  in_ready, out_valid, out_result
  );

  modport slave (
    input  in_valid, in_op, in_hi, in_src1_sgn, in_src2_sgn, in_src1, in_src2, out_ready,
    output in_ready, out_valid, out_result
  );
endinterface

// File: rtl/usb_control_cpu_mul_core.sv
// Registered signed (DATA_W+1)x(DATA_W+1) multiplier with load enable.
// Callers pre-extend operands so one signed array covers signed and unsigned forms.
module usb_control_cpu_mul_core #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic [DATA_W:0]       a,
  input  logic [DATA_W:0]       b,
  output logic [2*DATA_W+1:0]   p
);
  logic signed [2*DATA_W+1:0] a_w;
  logic signed [2*DATA_W+1:0] b_w;

  assign a_w = $signed({{(DATA_W+1){a[DATA_W]}}, a});
  assign b_w = $signed({{(DATA_W+1){b[DATA_W]}}, b});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  p <= '0;
    else if (en)   p <= a_w * b_w;
  end
endmodule

// File: rtl/usb_control_cpu_mul_shift_pipe.sv
// Pipelined multiply/shift unit; shifts reuse the multiplier via a 2^n operand.
// USB_CPU_MUL_HIGH_EN: when defined, MUL honours in_hi and the upper product half is carried.
module usb_control_cpu_mul_shift_pipe
  import usb_control_cpu_mul_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int PIPE_STAGES = 2,
  parameter int SH_W        = $clog2(DATA_W)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic flush,
  usb_control_cpu_mul_shift_pipe_if.slave bus
);
  localparam logic [DATA_W:0] ONE = {{DATA_W{1'b0}}, 1'b1};

  logic                   stall, adv, accept;
  logic [SH_W-1:0]        sh;
  logic                   sh_zero;
  logic [DATA_W:0]        a_ext, b_ext;
  logic                   hi_sel;
  logic [2*DATA_W+1:0]    prod;
  logic [1:0]             unused_prod_top;
  logic [DATA_W-1:0]      p_lo, p_hi, res;
  stage_ctl_t             s1_q;
  logic [PIPE_STAGES:2]   v_q;
  logic [DATA_W-1:0]      d_q [2:PIPE_STAGES];

  // Whole pipe freezes on a blocked output; flush still clears valids and keeps in_ready up.
  assign stall        = bus.out_valid && !bus.out_ready;
  assign adv          = !stall;
  assign bus.in_ready = adv || flush;
  assign accept       = bus.in_valid && bus.in_ready;

  assign sh      = bus.in_src2[SH_W-1:0];
  assign sh_zero = (sh == '0);

  // SHR is src1 * 2^(DATA_W-sh) read from the high half; sh=0 takes src1*1 from the low half.
  always_comb begin
    a_ext  = {1'b0, bus.in_src1};
    b_ext  = '0;
    hi_sel = 1'b0;
    case (bus.in_op)
      OP_MUL: begin
        a_ext = {bus.in_src1_sgn & bus.in_src1[DATA_W-1], bus.in_src1};
        b_ext = {bus.in_src2_sgn & bus.in_src2[DATA_W-1], bus.in_src2};
`ifdef USB_CPU_MUL_HIGH_EN
        hi_sel = bus.in_hi;
`endif
      end
      OP_SHR: begin
        a_ext  = {bus.in_src1_sgn & bus.in_src1[DATA_W-1], bus.in_src1};
        b_ext  = sh_zero ? ONE : (ONE << (DATA_W - int'(sh)));
        hi_sel = !sh_zero;
      end
      default: b_ext = ONE << sh;
    endcase
  end

`ifndef USB_CPU_MUL_HIGH_EN
  logic unused_hi;
  assign unused_hi = bus.in_hi;
`endif

  usb_control_cpu_mul_core #(.DATA_W(DATA_W)) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (adv),
    .a       (a_ext),
    .b       (b_ext),
    .p       (prod)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   s1_q       <= '0;
    else if (flush) s1_q.valid <= 1'b0;
    else if (adv)   s1_q       <= '{valid: accept, op: bus.in_op, hi: hi_sel};
  end

  assign unused_prod_top = prod[2*DATA_W+1:2*DATA_W];
  assign p_lo            = prod[DATA_W-1:0];
`ifdef USB_CPU_MUL_HIGH_EN
  assign p_hi = prod[2*DATA_W-1:DATA_W];
`else
  // Products are kept to DATA_W bits; only shift ops need the upper half.
  assign p_hi = (s1_q.op != OP_MUL) ? prod[2*DATA_W-1:DATA_W] : '0;
`endif

  always_comb begin
    res = s1_q.hi ? p_hi : p_lo;
    if (s1_q.op == OP_ROL) res = p_lo | p_hi;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q <= '0;
      for (int i = 2; i <= PIPE_STAGES; i++) d_q[i] <= '0;
    end else begin
      if (flush) begin
        v_q <= '0;
      end else if (adv) begin
        v_q[2] <= s1_q.valid;
        for (int i = 3; i <= PIPE_STAGES; i++) v_q[i] <= v_q[i-1];
      end
      if (adv) begin
        d_q[2] <= res;
        for (int i = 3; i <= PIPE_STAGES; i++) d_q[i] <= d_q[i-1];
      end
    end
  end

  assign bus.out_valid  = v_q[PIPE_STAGES];
  assign bus.out_result = d_q[PIPE_STAGES];
endmodule
